// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: default parameters
// and the 0-F segment table (bits [6:0] = g..a, active-high).
package seg_scan_pkg;

  localparam int DEF_NUM_DIGITS = 10;
  localparam int DEF_SEG_W      = 8;
  localparam int DEF_PRESCALE   = 1024;
  localparam int DEF_BRIGHT_W   = 4;

  // Element 0 is the rightmost entry.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to seven-segment decoder for the digit buffer write path.
// Used by seg_scan_ctrl only when SEG_SCAN_HEX_DECODE_EN is defined.
module seg_hex_decode
  import seg_scan_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [3:0]       nibble,
  input  logic             dp,
  output logic [SEG_W-1:0] pattern
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pattern      = '0;
    pattern[6:0] = HEX_TABLE[nibble];
    if (SEG_W == 8) pattern[SEG_W-1] = dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness and digit buffer.
// Optional write-path hex decode is compiled in with SEG_SCAN_HEX_DECODE_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int SEG_W       = DEF_SEG_W,
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int BRIGHT_W    = DEF_BRIGHT_W,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [SEG_W-1:0]              wr_data,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [SEG_W-1:0]              segm,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic                          frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(PRESCALE);
  localparam int STEP  = PRESCALE >> BRIGHT_W;

  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACT_LOW}};

  logic [SEG_W-1:0]    digit_buf [NUM_DIGITS];
  logic [SEG_W-1:0]    wr_pattern;
  logic [PRE_W-1:0]    pre_cnt;
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] bright_q;
  logic [BRIGHT_W-1:0] bright_eff;
  logic                last_pre;
  logic                last_idx;
  logic                lit;
  logic                wr_hit;

`ifdef SEG_SCAN_HEX_DECODE_EN
  seg_hex_decode #(.SEG_W(SEG_W)) u_decode (
    .nibble  (wr_data[3:0]),
    .dp      (wr_data[SEG_W-1]),
    .pattern (wr_pattern)
  );
`else
  assign wr_pattern = wr_data;
`endif

  assign wr_hit   = wr_en && (32'(wr_addr) < 32'(NUM_DIGITS));
  assign last_pre = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign last_idx = (idx == IDX_W'(NUM_DIGITS - 1));

  // Brightness is taken live on the first cycle of a slot, then held.
  assign bright_eff = (pre_cnt == '0) ? brightness : bright_q;
  assign lit        = enable && (32'(pre_cnt) < 32'(STEP) * (32'(bright_eff) + 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is small register storage, so it is reset to the blank
      // pattern; a RAM-inferred buffer would not be reset this way.
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= '0;
    end else if (wr_hit) begin
      digit_buf[wr_addr] <= wr_pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      pre_cnt    <= '0;
      idx        <= '0;
      bright_q   <= '0;
      frame_tick <= 1'b0;
      segm       <= SEG_OFF;
      sel        <= SEL_OFF;
    end else begin
      frame_tick <= enable && last_pre && last_idx;
      if (!enable) begin
        pre_cnt <= '0;
        idx     <= '0;
      end else begin
        pre_cnt <= last_pre ? '0 : pre_cnt + 1'b1;
        if (last_pre) idx <= last_idx ? '0 : idx + 1'b1;
      end
      if (pre_cnt == '0) bright_q <= brightness;
      // Outputs switch in a single edge, so one digit is never overlapped by the next.
      segm <= lit ? (digit_buf[idx] ^ SEG_OFF) : SEG_OFF;
      sel  <= lit ? ((NUM_DIGITS'(1) << idx) ^ SEL_OFF) : SEL_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, PRESCALE=16, BRIGHT_W=2) plus a
// 5-digit instance for out-of-range write addresses.
module tb_seg_scan_ctrl;

  localparam int ND   = 4;
  localparam int PS   = 16;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] brightness = 2'd3;
  logic [7:0] segm;
  logic [3:0] sel;
  logic       frame_tick;

  logic       enable5 = 1'b0;
  logic       wr_en5 = 1'b0;
  logic [2:0] wr_addr5 = '0;
  logic [7:0] wr_data5 = '0;
  logic [7:0] segm5;
  logic [4:0] sel5;
  logic       frame_tick5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pats [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
  logic [7:0] pats5 [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SEG_W(8), .PRESCALE(16), .BRIGHT_W(2)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .brightness(brightness), .segm(segm), .sel(sel),
    .frame_tick(frame_tick)
  );

  seg_scan_ctrl #(.NUM_DIGITS(5), .SEG_W(8), .PRESCALE(16), .BRIGHT_W(2)) u_dut5 (
    .clk(clk), .rst(rst), .enable(enable5), .wr_en(wr_en5), .wr_addr(wr_addr5),
    .wr_data(wr_data5), .brightness(brightness), .segm(segm5), .sel(sel5),
    .frame_tick(frame_tick5)
  );

  // Expected stored pattern for a value written through wr_data.
  function automatic logic [7:0] seg_pat(input logic [7:0] d);
`ifdef SEG_SCAN_HEX_DECODE_EN
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return {d[7], tbl[d[3:0]]};
`else
    return d;
`endif
  endfunction

  task automatic write_digit(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0000 || segm !== 8'h00 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: sel=%b segm=%h ft=%b, want 0000/00/0", sel, segm, frame_tick);
    end
    n_checks++;
    if (sel5 !== 5'b00000 || segm5 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold5: sel=%b segm=%h, want 00000/00", sel5, segm5);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0000 || segm !== 8'h00 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: sel=%b segm=%h ft=%b, want 0000/00/0", sel, segm, frame_tick);
    end
  endtask

  task automatic test_scan();
    int d;
    logic [3:0] e_sel;
    logic [7:0] e_seg;
    logic e_ft;
    brightness = 2'd3;
    for (int i = 0; i < 4; i++) write_digit(2'(i), pats[i]);
    enable = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      d = ((n - 1) / PS) % ND;
      e_sel = 4'(1 << d);
      e_seg = seg_pat(pats[d]);
      e_ft  = (n % 64 == 0);
      n_checks++;
      if (sel !== e_sel || segm !== e_seg || frame_tick !== e_ft) begin
        n_fail++;
        $display("FAIL scan n=%0d: sel=%b segm=%h ft=%b, want %b/%h/%b",
                 n, sel, segm, frame_tick, e_sel, e_seg, e_ft);
      end
    end
  endtask

  // Cases: brightness 0, brightness 1, and 0 changed to 3 mid-slot (held until next slot).
  task automatic test_brightness();
    int d, p, b;
    logic lit;
    logic [3:0] e_sel;
    logic [7:0] e_seg;
    for (int c = 0; c < 3; c++) begin
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sel !== 4'b0000 || segm !== 8'h00) begin
        n_fail++;
        $display("FAIL bright_off c=%0d: sel=%b segm=%h, want 0000/00", c, sel, segm);
      end
      brightness = (c == 1) ? 2'd1 : 2'd0;
      enable = 1'b1;
      for (int n = 1; n <= 64; n++) begin
        @(negedge clk);
        d = ((n - 1) / PS) % ND;
        p = (n - 1) % PS;
        b = (c == 1) ? 1 : ((c == 2 && n > PS) ? 3 : 0);
        lit = (p < STEP * (b + 1));
        e_sel = lit ? 4'(1 << d) : 4'b0000;
        e_seg = lit ? seg_pat(pats[d]) : 8'h00;
        n_checks++;
        if (sel !== e_sel || segm !== e_seg) begin
          n_fail++;
          $display("FAIL bright c=%0d n=%0d: sel=%b segm=%h, want %b/%h", c, n, sel, segm, e_sel, e_seg);
        end
        if (c == 2 && n == 2) brightness = 2'd3;
      end
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    @(negedge clk);
    brightness = 2'd3;
    enable = 1'b1;
    repeat (37) @(negedge clk);
    n_checks++;
    if (sel !== 4'b0100 || segm !== seg_pat(pats[2])) begin
      n_fail++;
      $display("FAIL en_slot2: sel=%b segm=%h, want 0100/%h", sel, segm, seg_pat(pats[2]));
    end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (sel !== 4'b0000 || segm !== 8'h00 || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL en_low k=%0d: sel=%b segm=%h ft=%b, want 0000/00/0", k, sel, segm, frame_tick);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0001 || segm !== seg_pat(pats[0])) begin
      n_fail++;
      $display("FAIL en_restart: sel=%b segm=%h, want 0001/%h", sel, segm, seg_pat(pats[0]));
    end
    repeat (16) @(negedge clk);
    n_checks++;
    if (sel !== 4'b0010 || segm !== seg_pat(pats[1])) begin
      n_fail++;
      $display("FAIL en_next: sel=%b segm=%h, want 0010/%h", sel, segm, seg_pat(pats[1]));
    end
  endtask

  task automatic test_write_lit();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++;
    if (sel !== 4'b0001 || segm !== seg_pat(pats[0])) begin
      n_fail++;
      $display("FAIL wr_edge1: sel=%b segm=%h, want 0001/%h", sel, segm, seg_pat(pats[0]));
    end
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0001 || segm !== seg_pat(8'hFF)) begin
      n_fail++;
      $display("FAIL wr_edge2: sel=%b segm=%h, want 0001/%h", sel, segm, seg_pat(8'hFF));
    end
  endtask

  task automatic test_addr_range();
    int d;
    logic [4:0] e_sel;
    brightness = 2'd3;
    for (int i = 0; i < 8; i++) begin
      wr_en5 = 1'b1; wr_addr5 = 3'(i); wr_data5 = (i < 5) ? pats5[i] : 8'hEE;
      @(negedge clk);
    end
    wr_en5 = 1'b0;
    enable5 = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      d = ((n - 1) / PS) % 5;
      e_sel = 5'(1 << d);
      n_checks++;
      if (sel5 !== e_sel || segm5 !== seg_pat(pats5[d]) || frame_tick5 !== (n == 80)) begin
        n_fail++;
        $display("FAIL addr_range n=%0d: sel=%b segm=%h ft=%b, want %b/%h/%b",
                 n, sel5, segm5, frame_tick5, e_sel, seg_pat(pats5[d]), (n == 80));
      end
    end
    enable5 = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [3:0] e_sel;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (sel !== 4'b0000 || segm !== 8'h00 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: sel=%b segm=%h ft=%b, want 0000/00/0", sel, segm, frame_tick);
    end
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0000 || segm !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_hold: sel=%b segm=%h, want 0000/00", sel, segm);
    end
    rst = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      e_sel = 4'(1 << (((n - 1) / PS) % ND));
      n_checks++;
      if (sel !== e_sel || segm !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_blank n=%0d: sel=%b segm=%h, want %b/00", n, sel, segm, e_sel);
      end
    end
  endtask

`ifdef SEG_SCAN_HEX_DECODE_EN
  task automatic test_hex();
    enable = 1'b0;
    write_digit(2'd0, 8'h8A);
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sel !== 4'b0001 || segm !== 8'hF7) begin
      n_fail++;
      $display("FAIL hex_a_dp: sel=%b segm=%h, want 0001/f7", sel, segm);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_enable_drop();
    test_write_lit();
    test_addr_range();
    test_rst_mid();
`ifdef SEG_SCAN_HEX_DECODE_EN
    test_hex();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
